hdmi_packet_parser: RTL and testbench

Receive-side counterpart of the HDMI data-island packet scheduler. It takes fully decoded, ECC-checked data-island packets (header plus four subpackets) and classifies them by type. It extracts ACR N/CTS, AVI InfoFrame fields and audio samples, and streams stereo samples out through a small FIFO. It sits between the TMDS/TERC4 decoder and the audio DAC / video-mode logic, all in the pixel clock domain.

---
 rtl/hdmi_packet_pkg.sv | 26 ++
 rtl/hdmi_packet_parser_if.sv | 46 ++++
 rtl/hdmi_audio_sample_fifo.sv | 48 ++++
 rtl/hdmi_packet_parser.sv | 173 +++++++++++++++++
 tb/tb_hdmi_packet_parser.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/hdmi_packet_pkg.sv
// hdmi_packet_pkg: shared definitions for the HDMI data-island packet parser.
//   - packet type codes (HB0)
//   - unpacker state encoding
//   - subpacket byte-select helper
package hdmi_packet_pkg;

    localparam logic [7:0] PKT_NULL  = 8'h00;
    localparam logic [7:0] PKT_ACR   = 8'h01;
    localparam logic [7:0] PKT_AUDIO = 8'h02;
    localparam logic [7:0] PKT_AVI   = 8'h82;
    localparam logic [7:0] PKT_SPD   = 8'h83;
    localparam logic [7:0] PKT_AIF   = 8'h84;

    typedef enum logic {
        IDLE,
        UNPACK
    } unpack_state_t;

    // Byte k (0..6) of a 56-bit subpacket.
    function automatic logic [7:0] sb_byte(input logic [55:0] i_sp, input int unsigned i_k);
        logic [55:0] w_shifted;
        w_shifted = i_sp >> (8 * i_k);
        return w_shifted[7:0];
    endfunction

endpackage

// File: rtl/hdmi_packet_parser_if.sv
// hdmi_packet_parser_if: bundles the parser's packet input bus, status/info
// outputs and the audio sample stream.
//   slave  : the parser (consumes packets, produces results)
//   master : the upstream decoder / downstream consumer side
interface hdmi_packet_parser_if #(
    parameter int unsigned AUDIO_BIT_WIDTH = 16
) ();
    logic                       packet_valid;
    logic                       packet_error;
    logic [23:0]                header;
    logic [3:0][55:0]           sub;
    logic                       video_field_end;
    logic [19:0]                acr_n;
    logic [19:0]                acr_cts;
    logic                       acr_valid;
    logic [6:0]                 avi_vic;
    logic [1:0]                 avi_color;
    logic [1:0]                 avi_aspect;
    logic                       avi_it_content;
    logic                       avi_valid;
    logic                       avi_lost;
    logic [AUDIO_BIT_WIDTH-1:0] audio_left;
    logic [AUDIO_BIT_WIDTH-1:0] audio_right;
    logic                       audio_block_start;
    logic                       audio_valid;
    logic                       audio_ready;
    logic                       audio_overflow;
    logic [7:0]                 checksum_error_count;
    logic [7:0]                 packet_error_count;

    modport slave (
        input  packet_valid, packet_error, header, sub, video_field_end, audio_ready,
        output acr_n, acr_cts, acr_valid,
        output avi_vic, avi_color, avi_aspect, avi_it_content, avi_valid, avi_lost,
        output audio_left, audio_right, audio_block_start, audio_valid, audio_overflow,
        output checksum_error_count, packet_error_count
    );

    modport master (
        output packet_valid, packet_error, header, sub, video_field_end, audio_ready,
        input  acr_n, acr_cts, acr_valid,
        input  avi_vic, avi_color, avi_aspect, avi_it_content, avi_valid, avi_lost,
        input  audio_left, audio_right, audio_block_start, audio_valid, audio_overflow,
        input  checksum_error_count, packet_error_count
    );
endinterface

// File: rtl/hdmi_audio_sample_fifo.sv
// hdmi_audio_sample_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   i_push    : write i_wdata; accepted when not full, or when full with a pop
//   i_pop     : remove head; ignored when empty
//   o_rdata   : head word, valid whenever !o_empty
//   o_full, o_empty : occupancy flags
module hdmi_audio_sample_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_wr;
    logic             w_rd;

    // Extra pointer MSB distinguishes full from empty.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || i_pop);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/hdmi_packet_parser.sv
// hdmi_packet_parser: classifies decoded HDMI data-island packets.
//   clk_pixel : pixel clock
//   reset     : asynchronous active-high reset
//   bus       : packet input, ACR N/CTS, AVI fields + watchdog, audio sample
//               stream (FWFT, valid/ready), overflow flag, error counters
module hdmi_packet_parser
    import hdmi_packet_pkg::*;
#(
    parameter int unsigned AUDIO_BIT_WIDTH  = 16,
    parameter int unsigned AUDIO_FIFO_DEPTH = 8
) (
    input  logic               clk_pixel,
    input  logic               reset,
    hdmi_packet_parser_if.slave bus
);
    localparam int unsigned W  = AUDIO_BIT_WIDTH;
    localparam int unsigned FW = 2 * W + 1;

    logic [7:0]       w_type;
    logic             w_good;
    logic [7:0]       w_sum;
    logic             w_is_info;
    logic             w_avi_good;
    logic             w_audio_pkt;

    logic [19:0]      r_acr_n, r_acr_cts;
    logic             r_acr_valid;
    logic [6:0]       r_avi_vic;
    logic [1:0]       r_avi_color, r_avi_aspect;
    logic             r_avi_it, r_avi_valid;
    logic [1:0]       r_field_cnt;
    logic [7:0]       r_cksum_err_cnt, r_pkt_err_cnt;
    logic             r_overflow;

    unpack_state_t    r_state, w_next_state;
    logic [3:0][55:0] r_hold;
    logic [3:0]       r_sp, r_b;
    logic [1:0]       r_idx;
    logic             w_push_req;
    logic [55:0]      w_sample;
    logic [FW-1:0]    w_wdata, w_rdata;
    logic             w_full, w_empty, w_pop, w_push;

    assign w_type      = bus.header[7:0];
    assign w_good      = bus.packet_valid && !bus.packet_error;
    assign w_is_info   = (w_type == PKT_AVI) || (w_type == PKT_SPD) || (w_type == PKT_AIF);
    assign w_avi_good  = w_good && (w_type == PKT_AVI) && (w_sum == 8'h00);
    assign w_audio_pkt = w_good && (w_type == PKT_AUDIO);

    always_comb begin
        w_sum = bus.header[7:0] + bus.header[15:8] + bus.header[23:16];
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned k = 0; k < 7; k++) begin
                w_sum = w_sum + sb_byte(bus.sub[i[1:0]], k);
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_acr_n         <= '0;
            r_acr_cts       <= '0;
            r_acr_valid     <= 1'b0;
            r_avi_vic       <= '0;
            r_avi_color     <= '0;
            r_avi_aspect    <= '0;
            r_avi_it        <= 1'b0;
            r_avi_valid     <= 1'b0;
            r_field_cnt     <= '0;
            r_cksum_err_cnt <= '0;
            r_pkt_err_cnt   <= '0;
        end else begin
            r_acr_valid <= w_good && (w_type == PKT_ACR);
            if (w_good && (w_type == PKT_ACR)) begin
                r_acr_cts <= {bus.sub[0][11:8], bus.sub[0][23:16], bus.sub[0][31:24]};
                r_acr_n   <= {bus.sub[0][35:32], bus.sub[0][47:40], bus.sub[0][55:48]};
            end
            if (bus.packet_valid && bus.packet_error && (r_pkt_err_cnt != 8'hFF))
                r_pkt_err_cnt <= r_pkt_err_cnt + 8'd1;
            if (w_good && w_is_info && (w_sum != 8'h00) && (r_cksum_err_cnt != 8'hFF))
                r_cksum_err_cnt <= r_cksum_err_cnt + 8'd1;
            if (w_avi_good) begin
                r_avi_color  <= bus.sub[0][14:13];
                r_avi_aspect <= bus.sub[0][21:20];
                r_avi_it     <= bus.sub[0][31];
                r_avi_vic    <= bus.sub[0][38:32];
                r_avi_valid  <= 1'b1;
            end
            // A good AVI beats a coincident field end; counter stops at 2 so
            // avi_lost stays asserted until the next good AVI.
            if (w_avi_good)
                r_field_cnt <= '0;
            else if (bus.video_field_end && (r_field_cnt != 2'd2))
                r_field_cnt <= r_field_cnt + 2'd1;
        end
    end

    // Unpacker: one subpacket slot per UNPACK cycle.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_push_req   = 1'b0;
        case (r_state)
            IDLE:    if (w_audio_pkt) w_next_state = UNPACK;
            UNPACK: begin
                w_push_req = r_sp[r_idx];
                if (r_idx == 2'd3) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_hold     <= '0;
            r_sp       <= '0;
            r_b        <= '0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_audio_pkt) begin
                r_hold <= bus.sub;
                r_sp   <= bus.header[11:8];
                r_b    <= bus.header[19:16];
                r_idx  <= '0;
            end else if (r_state == UNPACK) begin
                r_idx <= r_idx + 2'd1;
            end
            if (((r_state == UNPACK) && w_audio_pkt) || (w_push_req && w_full && !w_pop))
                r_overflow <= 1'b1;
        end
    end

    assign w_sample = r_hold[r_idx];
    assign w_wdata  = {w_sample[23:24-W], w_sample[47:48-W], r_b[r_idx]};
    assign w_pop    = !w_empty && bus.audio_ready;
    assign w_push   = w_push_req && (!w_full || w_pop);

    hdmi_audio_sample_fifo #(
        .WIDTH (FW),
        .DEPTH (AUDIO_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_pixel),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.acr_n                = r_acr_n;
    assign bus.acr_cts              = r_acr_cts;
    assign bus.acr_valid            = r_acr_valid;
    assign bus.avi_vic              = r_avi_vic;
    assign bus.avi_color            = r_avi_color;
    assign bus.avi_aspect           = r_avi_aspect;
    assign bus.avi_it_content       = r_avi_it;
    assign bus.avi_valid            = r_avi_valid;
    assign bus.avi_lost             = (r_field_cnt == 2'd2);
    assign bus.audio_left           = w_rdata[FW-1 -: W];
    assign bus.audio_right          = w_rdata[W:1];
    assign bus.audio_block_start    = w_rdata[0];
    assign bus.audio_valid          = !w_empty;
    assign bus.audio_overflow       = r_overflow;
    assign bus.checksum_error_count = r_cksum_err_cnt;
    assign bus.packet_error_count   = r_pkt_err_cnt;
endmodule

// File: tb/tb_hdmi_packet_parser.sv
// tb_hdmi_packet_parser: directed self-checking bench for hdmi_packet_parser.
module tb_hdmi_packet_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    hdmi_packet_parser_if #(.AUDIO_BIT_WIDTH(16)) bus ();

    hdmi_packet_parser #(
        .AUDIO_BIT_WIDTH  (16),
        .AUDIO_FIFO_DEPTH (8)
    ) dut (
        .clk_pixel (clk),
        .reset     (rst),
        .bus       (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One-cycle packet strobe; returns half a cycle after the capturing edge.
    task automatic send_pkt(input logic [23:0] hdr, input logic [3:0][55:0] s,
                            input logic err, input logic fe);
        @(negedge clk);
        bus.header          = hdr;
        bus.sub             = s;
        bus.packet_error    = err;
        bus.packet_valid    = 1'b1;
        bus.video_field_end = fe;
        @(negedge clk);
        bus.packet_valid    = 1'b0;
        bus.packet_error    = 1'b0;
        bus.video_field_end = 1'b0;
    endtask

    task automatic field_end();
        @(negedge clk);
        bus.video_field_end = 1'b1;
        @(negedge clk);
        bus.video_field_end = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] l, input logic [15:0] r,
                              input logic b);
        int n = 0;
        while (!bus.audio_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " valid"}, 32'(bus.audio_valid), 32'd1);
        check({tag, " left"},  32'(bus.audio_left),  32'(l));
        check({tag, " right"}, 32'(bus.audio_right), 32'(r));
        check({tag, " bstart"}, 32'(bus.audio_block_start), 32'(b));
        bus.audio_ready = 1'b1;
        @(negedge clk);
        bus.audio_ready = 1'b0;
    endtask

    // Test-3 audio packet: sp=1011, B=0001, left_i=0x123456*(i+1), right_i=0x111111*(i+1).
    task automatic send_audio3();
        logic [3:0][55:0] s;
        logic [23:0] l, r;
        for (int i = 0; i < 4; i++) begin
            l = 24'h123456 * 24'(i + 1);
            r = 24'h111111 * 24'(i + 1);
            s[i] = {8'h00, r, l};
        end
        send_pkt(24'h010B02, s, 1'b0, 1'b0);
    endtask

    // Full packet tagged by p: left={p,i,A5C3}, right={i,p,5A3C}, B=0001.
    task automatic send_audio_full(input int p);
        logic [3:0][55:0] s;
        for (int i = 0; i < 4; i++)
            s[i] = {8'h00, 4'(i), 4'(p), 16'h5A3C, 4'(p), 4'(i), 16'hA5C3};
        send_pkt(24'h010F02, s, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0][55:0] s;
        bus.packet_valid    = 1'b0;
        bus.packet_error    = 1'b0;
        bus.header          = '0;
        bus.sub             = '0;
        bus.video_field_end = 1'b0;
        bus.audio_ready     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst acr_n", 32'(bus.acr_n), 32'd0);
        check("rst avi_valid", 32'(bus.avi_valid), 32'd0);
        check("rst audio_valid", 32'(bus.audio_valid), 32'd0);
        check("rst overflow", 32'(bus.audio_overflow), 32'd0);
        check("rst avi_lost", 32'(bus.avi_lost), 32'd0);
        rst = 1'b0;

        // Errored ACR: counted, otherwise ignored
        s = '0;
        s[0] = 56'h80_18_00_A0_86_01_00;
        send_pkt(24'h000001, s, 1'b1, 1'b0);
        check("err acr_valid", 32'(bus.acr_valid), 32'd0);
        check("err count", 32'(bus.packet_error_count), 32'd1);
        check("err acr_n", 32'(bus.acr_n), 32'd0);

        // 1: ACR
        send_pkt(24'h000001, s, 1'b0, 1'b0);
        check("acr pulse", 32'(bus.acr_valid), 32'd1);
        check("acr cts", 32'(bus.acr_cts), 32'h186A0);
        check("acr n", 32'(bus.acr_n), 32'h01880);
        @(negedge clk);
        check("acr pulse end", 32'(bus.acr_valid), 32'd0);

        // 2: AVI VIC16, M=10, IT=1; PB0 = 0x100 - 0x41 = 0xBF
        s = '0;
        s[0] = 56'h00_00_10_80_20_00_BF;
        send_pkt(24'h0D0282, s, 1'b0, 1'b0);
        check("avi vic", 32'(bus.avi_vic), 32'd16);
        check("avi aspect", 32'(bus.avi_aspect), 32'd2);
        check("avi color", 32'(bus.avi_color), 32'd0);
        check("avi it", 32'(bus.avi_it_content), 32'd1);
        check("avi valid", 32'(bus.avi_valid), 32'd1);
        s[0] = 56'h00_00_10_80_20_00_C0;
        send_pkt(24'h0D0282, s, 1'b0, 1'b0);
        check("avi bad cnt", 32'(bus.checksum_error_count), 32'd1);
        s[0] = 56'h00_00_05_80_20_00_BF;
        send_pkt(24'h0D0282, s, 1'b0, 1'b0);
        check("avi bad cnt2", 32'(bus.checksum_error_count), 32'd2);
        check("avi bad vic", 32'(bus.avi_vic), 32'd16);

        // 5: watchdog
        field_end();
        check("wd after 1", 32'(bus.avi_lost), 32'd0);
        field_end();
        check("wd after 2", 32'(bus.avi_lost), 32'd1);
        s[0] = 56'h00_00_10_80_20_00_BF;
        send_pkt(24'h0D0282, s, 1'b0, 1'b1);
        check("wd avi wins", 32'(bus.avi_lost), 32'd0);

        // 3: sparse audio packet
        send_audio3();
        pop_expect("a3 s0", 16'h1234, 16'h1111, 1'b1);
        pop_expect("a3 s1", 16'h2468, 16'h2222, 1'b0);
        pop_expect("a3 s3", 16'h48D1, 16'h4444, 1'b0);
        repeat (3) @(negedge clk);
        check("a3 drained", 32'(bus.audio_valid), 32'd0);
        check("a3 no ovf", 32'(bus.audio_overflow), 32'd0);

        // 4: overflow with consumer stalled
        for (int p = 0; p < 3; p++) begin
            send_audio_full(p);
            repeat (30) @(negedge clk);
        end
        check("ovf flag", 32'(bus.audio_overflow), 32'd1);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 4; i++)
                pop_expect($sformatf("ovf p%0d s%0d", p, i), {4'(p), 4'(i), 8'hA5},
                           {4'(i), 4'(p), 8'h5A}, (i == 0));
        check("ovf kept 8", 32'(bus.audio_valid), 32'd0);

        // Packet-error counter saturation
        for (int i = 0; i < 260; i++) send_pkt(24'h000000, '0, 1'b1, 1'b0);
        check("err sat", 32'(bus.packet_error_count), 32'd255);

        // 6: reset mid-UNPACK with two samples buffered
        send_audio_full(5);
        @(negedge clk);
        @(negedge clk);
        check("r6 pre valid", 32'(bus.audio_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("r6 valid", 32'(bus.audio_valid), 32'd0);
        check("r6 errcnt", 32'(bus.packet_error_count), 32'd0);
        check("r6 ckcnt", 32'(bus.checksum_error_count), 32'd0);
        check("r6 ovf", 32'(bus.audio_overflow), 32'd0);
        check("r6 avi", 32'(bus.avi_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("r6 idle", 32'(bus.audio_valid), 32'd0);
        send_audio3();
        pop_expect("r6 s0", 16'h1234, 16'h1111, 1'b1);
        pop_expect("r6 s1", 16'h2468, 16'h2222, 1'b0);
        pop_expect("r6 s3", 16'h48D1, 16'h4444, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
